// File: rtl/capture_pkg.sv
// Shared types for the triggered sample recorder.
// Holds the capture FSM encoding and the default RAM depth.
package capture_pkg;

  localparam int DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: one synchronous write port, one registered read port.
// A same-address write and read in one cycle return the old word.
module capture_ram #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/sample_capture.sv
// Triggered sample recorder: rolling pre-trigger history, level-crossing
// trigger, then post-trigger fill before freezing the window for readout.
module sample_capture
  import capture_pkg::*;
#(
  parameter int A_WIDTH  = $clog2(DEPTH),
  parameter int D_WIDTH  = 8,
  parameter int PRE_TRIG = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               arm,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] trig_addr
);

  localparam logic [A_WIDTH-1:0] pre_w =
    A_WIDTH'(PRE_TRIG);
  localparam logic [A_WIDTH-1:0] pre_last =
    A_WIDTH'(PRE_TRIG - 1);
  localparam logic [A_WIDTH-1:0] post_w =
    A_WIDTH'((2**A_WIDTH) - PRE_TRIG - 1);

  cap_state_t         state;
  logic [A_WIDTH-1:0] wptr;
  logic [A_WIDTH-1:0] cnt;
  logic [D_WIDTH-1:0] prev;
  logic               act;
  logic               we;
  logic               hit;
  logic [A_WIDTH-1:0] raddr;

  always_comb begin
    act   = (state == PRE) || (state == ARMED) ||
            (state == POST);
    we    = en && act;
    hit   = (prev < trig_level) && (din >= trig_level);
    raddr = trig_addr - pre_w + rd_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      cnt       <= '0;
      prev      <= '0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state <= PRE;
            busy  <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            prev  <= '1;
          end
        end
        PRE: begin
          if (en) begin
            prev <= din;
            cnt  <= cnt + 1'b1;
            if (cnt == pre_last) state <= ARMED;
          end
        end
        ARMED: begin
          if (en) begin
            prev <= din;
            if (hit) begin
              trig_addr <= wptr;
              cnt       <= post_w;
              // A zero-length post window freezes on the trigger itself
              if (post_w == '0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (en) begin
            cnt <= cnt - 1'b1;
            if (cnt == A_WIDTH'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  capture_ram #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wptr),
    .wdata(din),
    .raddr(raddr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture (16-deep RAM, 4 pre-trigger).
// A sample-history model predicts the frozen window and trigger address.
module tb_sample_capture;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int PT  = 4;
  localparam int N   = 16;
  localparam int LVL = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          arm;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  sample_capture #(
    .A_WIDTH (AW),
    .D_WIDTH (DW),
    .PRE_TRIG(PT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .arm       (arm),
    .trig_level(trig_level),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 pre, 2 armed, 3 post, 4 done
  int phase  = 0;
  int npre   = 0;
  int nrem   = 0;
  int wcount = 0;
  int wbase  = 0;
  int tidx   = 0;
  int prevm  = 0;
  int hist[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic model(input logic e, input int d,
                       input logic a);
    if (a && (phase == 0 || phase == 4)) begin
      phase = 1;
      npre  = 0;
      prevm = 255;
      hist.delete();
      wbase = wcount;
    end else if (e && phase >= 1 && phase <= 3) begin
      hist.push_back(d);
      wcount++;
      case (phase)
        1: begin
          npre++;
          prevm = d;
          if (npre == PT) phase = 2;
        end
        2: begin
          if (prevm < LVL && d >= LVL) begin
            tidx  = hist.size() - 1;
            nrem  = N - PT - 1;
            phase = (nrem == 0) ? 4 : 3;
          end
          prevm = d;
        end
        default: begin
          nrem--;
          if (nrem == 0) phase = 4;
        end
      endcase
    end
  endtask

  task automatic drive(input logic e, input int d,
                       input logic a);
    en  = e;
    din = DW'(d);
    arm = a;
    model(e, d, a);
    @(posedge clk);
    #1;
    chk("busy", busy, (phase >= 1 && phase <= 3));
    chk("done", done, (phase == 4));
    en  = 1'b0;
    arm = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      @(posedge clk);
      #1;
      chk("rd_data", rd_data, hist[tidx - PT + i]);
    end
    chk("trig_addr", trig_addr, (wbase + tidx) % N);
    rd_addr = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig", trig_addr, 0);
    chk("rst_rd", rd_data, 0);
    phase  = 0;
    wcount = 0;
    hist.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // mode 0 ramp, 1 ramp with en gaps, 2 random, 3 ramp + stray arm
  task automatic capture(input int mode, input bit stop_post);
    int   k;
    int   cyc;
    int   d;
    logic e;
    logic a;
    k   = 0;
    cyc = 0;
    drive(1'b0, 0, 1'b1);
    while (phase != 4 && cyc < 400) begin
      a = 1'b0;
      case (mode)
        1: begin
          e = (cyc % 2 == 0);
          d = k;
          if (e) k++;
        end
        2: begin
          e = ($urandom_range(0, 3) != 0);
          d = $urandom_range(0, 20);
        end
        default: begin
          e = 1'b1;
          d = k;
          k++;
          a = (mode == 3 && phase == 2 && k == 8);
        end
      endcase
      drive(e, d, a);
      cyc++;
      if (stop_post && phase == 3 && nrem < 6) break;
    end
    if (!stop_post) begin
      chk("timeout", phase, 4);
      if (phase == 4) readback();
    end
  endtask

  initial begin
    int seq[6];
    int k;
    seq = '{0, 15, 0, 0, 5, 12};
    rst        = 1'b1;
    en         = 1'b0;
    arm        = 1'b0;
    din        = '0;
    rd_addr    = '0;
    trig_level = DW'(LVL);
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_reset();

    capture(0, 1'b0);
    chk("s2_trig", trig_addr, 10);
    chk("s2_done", done, 1);

    capture(1, 1'b0);
    capture(3, 1'b0);

    capture(0, 1'b1);
    do_reset();
    capture(0, 1'b0);

    do_reset();
    drive(1'b0, 0, 1'b1);
    foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
    chk("s3_trig", trig_addr, 5);
    k = 20;
    while (phase != 4 && k < 60) begin
      drive(1'b1, k, 1'b0);
      k++;
    end
    chk("s3_timeout", phase, 4);
    readback();

    for (int r = 0; r < 4; r++) capture(2, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
